// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and helpers for the serial word-to-bit blocks
package serial_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } serializer_state_t;

    // Counter wide enough to hold the values 0..width
    function automatic int counter_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/parallel_to_serial_msb_first.sv
// rtl/parallel_to_serial_msb_first.sv - MSB-first word serializer with first/last markers; optional macro PARALLEL_TO_SERIAL_BACK_TO_BACK_EN
module parallel_to_serial_msb_first #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_first,
    output logic             out_last
);
    import serial_pkg::*;

    localparam int            CW   = counter_width(WIDTH);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    serializer_state_t state;
    logic [WIDTH-1:0]  shreg;
    logic [CW-1:0]     bits_left;
    logic              shifting;
    logic              in_xfer;
    logic              beat;

    assign shifting  = (state == SHIFT);

    // Outputs come straight from registered state and are zero outside a word
    assign out_valid = shifting;
    assign out_bit   = shifting & shreg[WIDTH-1];
    assign out_first = shifting && (bits_left == FULL);
    assign out_last  = shifting && (bits_left == ONE);

`ifdef PARALLEL_TO_SERIAL_BACK_TO_BACK_EN
    // Accept the next word on the edge that consumes the current last bit
    assign in_ready = !rst && ((state == IDLE) || (shifting && out_last && out_ready));
`else
    // One bubble cycle between words: accept only while idle
    assign in_ready = !rst && (state == IDLE);
`endif

    assign in_xfer = in_valid && in_ready;
    assign beat    = out_valid && out_ready;

    // FSM, shift register and remaining-bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bits_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        shreg     <= in_data;
                        bits_left <= FULL;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (in_xfer) begin
                        shreg     <= in_data;
                        bits_left <= FULL;
                    end else if (beat) begin
                        shreg     <= shreg << 1;
                        bits_left <= bits_left - ONE;
                        if (out_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/parallel_to_serial_msb_first.md
# parallel_to_serial_msb_first

Converts a WIDTH-bit parallel word, accepted over a valid/ready handshake, into a bit stream emitted MSB first, one bit per accepted output beat. Sits directly upstream of the serial divisibility checkers (by 3, by 5). Delimits each word with first/last markers so downstream glue can clear the checker at word start and sample its result after the last bit.

## Interface
- WIDTH, 8, word width in bits; legal range WIDTH >= 1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream word present
- in_ready  out  1  block can accept a word this cycle
- in_data  in  WIDTH  word to serialize; bit WIDTH-1 is sent first
- out_valid  out  1  out_bit is meaningful this cycle
- out_ready  in  1  downstream consumes out_bit this cycle
- out_bit  out  1  current serial bit
- out_first  out  1  current bit is bit WIDTH-1 of its word
- out_last  out  1  current bit is bit 0 of its word

## Operation
- Two-state FSM: IDLE, SHIFT.
- Input transfer: in_valid && in_ready at a rising edge. Output beat: out_valid && out_ready at a rising edge.
- IDLE: in_ready = 1, out_valid = 0. On input transfer, load in_data into the shift register, load bits_left = WIDTH, and go to SHIFT.
- SHIFT: out_valid = 1, out_bit = shift register MSB, out_first = (bits_left == WIDTH), out_last = (bits_left == 1).
- On output beat in SHIFT: shift left by one (zero fill) and decrement bits_left. On a beat with out_last = 1, go to IDLE.
- out_ready low in SHIFT: all state held. out_bit, out_first and out_last stay stable and out_valid stays 1 (no valid drop).
- in_data is sampled only at an input transfer. Changes at any other time are ignored.
- WIDTH = 1: out_first and out_last are both 1 on the single bit.
- When out_valid = 0: out_bit, out_first and out_last are driven 0.
- Reset values: state IDLE, shift register 0, bits_left 0. Hence out_valid = 0, out_bit = 0, out_first = 0, out_last = 0.
- in_ready is forced 0 while rst is high and is 1 in the first cycle after rst deasserts.
- Reset mid-word: the word is discarded and no further bits are emitted. The next output is a fresh word beginning with out_first.
- Downstream glue rule: out_valid && out_ready && out_first clears the checker while its bit is consumed. The checker result is valid the cycle after the out_last beat.

## Timing
- Latency: a word accepted at edge t presents its MSB in cycle t+1. Register outputs only; no combinational in-to-out path except the in_ready dependence described under Configuration.
- With out_ready held at 1, a word occupies WIDTH consecutive cycles.
- Default throughput: one idle bubble cycle between words, i.e. WIDTH+1 cycles per word.
- in_valid asserted while in SHIFT (macro off): in_ready = 0. The word must be held by upstream until accepted.

## Configuration
- Macro: PARALLEL_TO_SERIAL_BACK_TO_BACK_EN.
- Undefined: in_ready = (state == IDLE) && !rst. One bubble cycle between words.
- Defined:
  - in_ready = !rst && (IDLE || (SHIFT && out_last && out_ready)). This is combinational from out_ready.
  - A transfer on the last-bit edge reloads the shift register, sets bits_left = WIDTH and stays in SHIFT.
  - The next word's MSB follows bit 0 with no gap, giving sustained throughput of WIDTH cycles per word.

## Structure
- Shared package serial_pkg:
  - typedef enum logic [0:0] { IDLE, SHIFT } serializer_state_t
  - localparam function for the counter width, $clog2(WIDTH+1)
- The divisibility checkers import nothing new from the package.
- No sub-module: the shift register, counter and FSM live in one module. The word-level checker wrapper pairing this block with a checker is a separate block.

## Test plan
- WIDTH=8, single word 8'hA5, out_ready=1 → bits 1,0,1,0,0,1,0,1 in cycles t+1..t+8; out_first only at t+1, out_last only at t+8; out_valid=0 at t+9. Through the div-by-5 checker, 165 gives div_by_5=1 at t+9.
- Words 8'h0F then 8'hF0 offered back to back:
  - Macro off: one cycle with out_valid=0 between the words; second word accepted at t+9.
  - Macro on: second word accepted at t+8; its MSB 1 appears at t+9 with out_first=1.
- Stall: word 8'hC3, out_ready=0 for 3 cycles after the 3rd bit → out_bit=0 held with out_valid=1 for 3 cycles; total 11 cycles; bit sequence unchanged.
- in_valid with 8'hFF asserted while the word 8'h01 is in SHIFT (macro off) → in_ready=0; 8'h01 completes; 8'hFF accepted the next IDLE cycle.
- rst asserted on the 4th bit of 8'h5A → next cycle out_valid=0, out_first=0, out_last=0, in_ready=1; new word 8'h0A streams from its MSB with out_first=1; checker reports 10 divisible by 5.
- WIDTH=1, word 1'b1 → a single cycle with out_first=out_last=1 and out_bit=1.
